// File: rtl/pe_host_link.sv
// Host-side buffer for one PE: collects a load frame from an upstream stream,
// replays it as a gap-free burst, captures the result burst and streams it back out.
module pe_host_link #(
  parameter int DATA_WIDTH = 16,
  parameter int LOAD_NUM   = 16,
  parameter int OUT_NUM    = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH*2-1:0] s_data,
  output logic                    s_ready,
  output logic                    din_pe_v,
  output logic [DATA_WIDTH*2-1:0] din_pe,
  input  logic                    dout_pe_v,
  input  logic [DATA_WIDTH*2-1:0] dout_pe,
  output logic                    m_valid,
  output logic [DATA_WIDTH*2-1:0] m_data,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    err
);
  localparam int DW  = DATA_WIDTH * 2;
  localparam int LCW = $clog2(LOAD_NUM + 1);
  localparam int OCW = $clog2(OUT_NUM + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int LIW = (LOAD_NUM > 1) ? $clog2(LOAD_NUM) : 1;
  localparam int OIW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;

  localparam logic [LCW-1:0] LOAD_CNT  = LCW'(LOAD_NUM);
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_NUM - 1);
  localparam logic [OCW-1:0] OUT_LAST  = OCW'(OUT_NUM - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_SEND,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [LCW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LCW-1:0]  snd_cnt_q, snd_cnt_d;
  logic [OCW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [OCW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [TCW-1:0]  to_cnt_q, to_cnt_d;
  logic            din_v_q, din_v_d;
  logic [DW-1:0]   din_q, din_d;
  logic            err_q, err_d;

  logic            lbuf_we;
  logic            rbuf_we;
  logic [OIW-1:0]  rbuf_widx;

  logic [DW-1:0]   lbuf [LOAD_NUM];
  logic [DW-1:0]   rbuf [OUT_NUM];

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    snd_cnt_d = snd_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    din_v_d   = 1'b0;
    din_d     = '0;
    lbuf_we   = 1'b0;
    rbuf_we   = 1'b0;
    rbuf_widx = rd_cnt_q[OIW-1:0];

    unique case (state_q)
      S_FILL: begin
        if (s_valid) begin
          lbuf_we = 1'b1;
          if (wr_cnt_q == LOAD_LAST) begin
            wr_cnt_d = '0;
            state_d  = S_SEND;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
        if (dout_pe_v) err_d = 1'b1;
      end

      // One extra cycle after the last word drops valid and hands over to WAIT.
      S_SEND: begin
        if (snd_cnt_q == LOAD_CNT) begin
          snd_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = S_WAIT;
        end else begin
          din_v_d   = 1'b1;
          din_d     = lbuf[snd_cnt_q[LIW-1:0]];
          snd_cnt_d = snd_cnt_q + 1'b1;
        end
        if (dout_pe_v) err_d = 1'b1;
      end

      S_WAIT: begin
        if (dout_pe_v) begin
          rbuf_we   = 1'b1;
          rbuf_widx = '0;
          to_cnt_d  = '0;
          if (OUT_NUM == 1) begin
            rd_cnt_d = '0;
            state_d  = S_DRAIN;
          end else begin
            rd_cnt_d = OCW'(1);
            state_d  = S_CAPTURE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d = '0;
          err_d    = 1'b1;
          state_d  = S_FILL;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        if (dout_pe_v) begin
          rbuf_we = 1'b1;
          if (rd_cnt_q == OUT_LAST) begin
            rd_cnt_d = '0;
            state_d  = S_DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (m_ready) begin
          if (tx_cnt_q == OUT_LAST) begin
            tx_cnt_d = '0;
            state_d  = S_FILL;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
        if (dout_pe_v) err_d = 1'b1;
      end

      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILL;
      wr_cnt_q  <= '0;
      snd_cnt_q <= '0;
      rd_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      to_cnt_q  <= '0;
      din_v_q   <= 1'b0;
      din_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      snd_cnt_q <= snd_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      to_cnt_q  <= to_cnt_d;
      din_v_q   <= din_v_d;
      din_q     <= din_d;
      err_q     <= err_d;
    end
  end

  // Buffer contents need no reset: the counters decide what is valid.
  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf[wr_cnt_q[LIW-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rbuf_we) rbuf[rbuf_widx] <= dout_pe;
  end

  assign s_ready  = (state_q == S_FILL);
  assign busy     = (state_q != S_FILL);
  assign m_valid  = (state_q == S_DRAIN);
  assign m_data   = m_valid ? rbuf[tx_cnt_q[OIW-1:0]] : '0;
  assign din_pe_v = din_v_q;
  assign din_pe   = din_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pe_host_link.sv
// Directed bench for pe_host_link: scoreboard queues for the load burst and the
// result stream, plus a small PE model that answers each load burst.
module tb_pe_host_link;
  localparam int DW       = 16;
  localparam int LN       = 16;
  localparam int ON       = 4;
  localparam int TO       = 64;
  localparam int PE_DELAY = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        din_pe_v;
  logic [31:0] din_pe;
  logic        dout_pe_v;
  logic [31:0] dout_pe;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  pe_host_link #(
    .DATA_WIDTH(DW),
    .LOAD_NUM  (LN),
    .OUT_NUM   (ON),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .din_pe_v (din_pe_v),
    .din_pe   (din_pe),
    .dout_pe_v(dout_pe_v),
    .dout_pe  (dout_pe),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .busy     (busy),
    .err      (err)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] load_q[$];
  logic [31:0] res_q[$];

  int          cyc_n         = 0;
  int          din_run       = 0;
  int          din_fall_cyc  = -1;
  int          last_acc_cyc  = -1;
  int          last_emit_cyc = -1;
  int          err_rise_cyc  = -1;
  int          drained       = 0;
  bit          prev_din = 0, prev_mv = 0, prev_mr = 0, prev_err = 0;
  logic [31:0] prev_md = '0;

  bit pe_respond = 1, pe_armed = 0, pe_active = 0, pe_gap = 0, gap_done = 0, spur = 0;
  int pe_wait = 0, pe_emit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PE model: answers PE_DELAY idle cycles after a load burst with 0xA0..0xA3.
  task automatic pe_model();
    dout_pe_v = 1'b0;
    dout_pe   = '0;
    if (spur) begin
      spur      = 0;
      dout_pe_v = 1'b1;
      dout_pe   = 32'hDEAD0000;
    end else if (pe_active) begin
      if (pe_gap && pe_emit == 2 && !gap_done) begin
        gap_done = 1;
      end else begin
        dout_pe_v = 1'b1;
        dout_pe   = 32'hA0 + pe_emit;
        res_q.push_back(dout_pe);
        last_emit_cyc = cyc_n;
        pe_emit++;
        if (pe_emit == ON) pe_active = 0;
      end
    end else if (pe_armed && !din_pe_v) begin
      pe_wait++;
      if (pe_wait == PE_DELAY) begin
        pe_armed = 0;
        if (pe_respond) begin
          pe_active = 1;
          pe_emit   = 0;
          gap_done  = 0;
        end
      end
    end
    if (din_pe_v) begin
      pe_armed = 1;
      pe_wait  = 0;
    end
  endtask

  task automatic observe();
    chk("s_ready_vs_busy", 32'(s_ready), 32'(!busy));
    if (s_valid && s_ready) begin
      load_q.push_back(s_data);
      last_acc_cyc = cyc_n;
    end
    if (din_pe_v) begin
      if (!prev_din) chk("load_latency", cyc_n - last_acc_cyc, 2);
      din_run++;
      chk("s_ready_in_send", 32'(s_ready), 0);
      chk("din_expected", 32'(load_q.size() > 0), 1);
      if (load_q.size() > 0) chk("din_pe", din_pe, load_q.pop_front());
    end else begin
      if (prev_din) begin
        chk("burst_len", din_run, LN);
        din_fall_cyc = cyc_n;
      end
      din_run = 0;
      chk("din_idle_zero", din_pe, 0);
    end
    if (prev_mv && !prev_mr) begin
      chk("m_valid_hold", 32'(m_valid), 1);
      chk("m_data_hold", m_data, prev_md);
    end
    if (m_valid && !prev_mv && last_emit_cyc >= 0)
      chk("result_latency", cyc_n - last_emit_cyc, 1);
    if (m_valid && m_ready) begin
      chk("res_expected", 32'(res_q.size() > 0), 1);
      if (res_q.size() > 0) chk("m_data", m_data, res_q.pop_front());
      drained++;
    end
    if (err && !prev_err) err_rise_cyc = cyc_n;
    prev_din = din_pe_v;
    prev_mv  = m_valid;
    prev_mr  = m_ready;
    prev_md  = m_data;
    prev_err = err;
    cyc_n++;
  endtask

  task automatic cyc();
    pe_model();
    observe();
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] base, input bit throttle);
    int guard;
    bit acc;
    for (int i = 0; i < LN; i++) begin
      guard = 0;
      acc   = 0;
      while (!acc && guard < 200) begin
        s_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = base + 32'(i);
        acc     = s_valid && s_ready;
        cyc();
        guard++;
      end
      chk("word_accepted", 32'(acc), 1);
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic wait_drain(input int target);
    int guard;
    guard = 0;
    while (drained < target && guard < 400) begin
      cyc();
      guard++;
    end
    chk("drain_count", drained, target);
    repeat (2) cyc();
    chk("m_valid_after_drain", 32'(m_valid), 0);
    chk("s_ready_after_drain", 32'(s_ready), 1);
  endtask

  initial begin
    int guard;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    dout_pe_v = 1'b0;
    dout_pe   = '0;
    m_ready   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_din_pe_v", 32'(din_pe_v), 0);
    chk("rst_din_pe", din_pe, 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    rst = 1'b0;

    // Basic frame
    drained = 0;
    send_frame(32'h00010000, 0);
    wait_drain(ON);
    chk("basic_err", 32'(err), 0);
    chk("basic_load_q_empty", load_q.size(), 0);

    // Upstream throttling, with a one-cycle gap inside the result burst
    drained = 0;
    pe_gap  = 1;
    send_frame(32'h00020000, 1);
    wait_drain(ON);
    pe_gap = 0;
    chk("throttle_err", 32'(err), 0);

    // Downstream backpressure
    drained = 0;
    m_ready = 1'b0;
    send_frame(32'h00030000, 0);
    guard = 0;
    while (!m_valid && guard < 300) begin
      cyc();
      guard++;
    end
    chk("bp_m_valid", 32'(m_valid), 1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_m_data", m_data, 32'hA0);
      chk("bp_s_ready", 32'(s_ready), 0);
      cyc();
    end
    m_ready = 1'b1;
    wait_drain(ON);
    chk("bp_err", 32'(err), 0);

    // Timeout: PE never answers
    pe_respond   = 0;
    err_rise_cyc = -1;
    send_frame(32'h00040000, 0);
    guard = 0;
    while (err_rise_cyc < 0 && guard < 300) begin
      cyc();
      guard++;
    end
    chk("timeout_seen", 32'(err_rise_cyc >= 0), 1);
    chk("timeout_cycles", err_rise_cyc - din_fall_cyc, TO);
    chk("timeout_s_ready", 32'(s_ready), 1);
    chk("timeout_busy", 32'(busy), 0);
    pe_respond = 1;

    // Reset on the 5th load cycle
    send_frame(32'h00050000, 0);
    guard = 0;
    while (din_run < 4 && guard < 50) begin
      cyc();
      guard++;
    end
    chk("rst5_din_pe_v", 32'(din_pe_v), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst5_next_din_pe_v", 32'(din_pe_v), 0);
    chk("rst5_din_pe", din_pe, 0);
    chk("rst5_m_valid", 32'(m_valid), 0);
    chk("rst5_m_data", m_data, 0);
    chk("rst5_err", 32'(err), 0);
    chk("rst5_busy", 32'(busy), 0);
    rst = 1'b0;
    load_q.delete();
    res_q.delete();
    din_run       = 0;
    prev_din      = 0;
    prev_mv       = 0;
    prev_err      = 0;
    pe_armed      = 0;
    pe_active     = 0;
    err_rise_cyc  = -1;
    last_acc_cyc  = -1;
    last_emit_cyc = -1;
    chk("rst5_s_ready", 32'(s_ready), 1);
    repeat (3) cyc();
    chk("rst5_idle_din", 32'(din_pe_v), 0);

    // Spurious result during FILL, then a normal frame
    spur = 1;
    cyc();
    chk("spur_err", 32'(err), 1);
    chk("spur_s_ready", 32'(s_ready), 1);
    drained = 0;
    send_frame(32'h00060000, 0);
    wait_drain(ON);
    chk("spur_err_sticky", 32'(err), 1);
    chk("spur_res_q_empty", res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
